// File: rtl/mem_stage.sv
// ---------------------------------------------------------------------------
// mem_stage -- MIPS memory-access stage (sits directly after EX).
//
// Takes the EX ALU result (effective address or plain value), the store data
// (rt) and the instruction. Non-memory instructions pass straight through to
// WB with one cycle of latency. Loads and stores run over a req/ack data bus,
// and Stall is held towards EX while an access is outstanding.
//
// Parameters
//   TIMEOUT_CYCLES  ACCESS cycles without DAck before the access is abandoned
//                   and reported with BusErr (1..1023).
//
// Optional feature (compile-time macro)
//   MEM_ALIGN_CHECK_EN  defined  : misaligned LH/LHU/SH/LW/SW do no bus access
//                                  and are reported with AddrErr.
//                       undefined: low address bits below the access size are
//                                  ignored (access forced aligned), AddrErr = 0.
//
// Ports
//   CLK, RST          clock; synchronous active-high reset
//   InValid           Ins/Result/Rdata2 carry an instruction this cycle
//   Ins, Result       instruction and ALU result from EX
//   Rdata2            store data (rt)
//   Stall             combinational; EX holds its outputs while high
//   DReq/DWe/DBe      data-bus request, write flag, byte enables (lane 0 = 7:0)
//   DAddr, DWdata     word address and lane-replicated store data
//   DRdata, DAck      read data and one-cycle completion strobe
//   OutValid          one-cycle pulse: WbData/WbIns/BusErr/AddrErr valid
//   WbData, WbIns     write-back value and instruction (held between pulses)
//   BusErr, AddrErr   error qualifiers of the OutValid pulse
//   DbgState          current FSM state (0 = IDLE, 1 = ACCESS)
//
// Data-bus handshake: DReq rises on the edge that enters ACCESS together with
// DWe/DBe/DAddr/DWdata, and all five stay constant until the cycle in which
// DAck is sampled high. DAck is a single-cycle strobe; DRdata is only looked
// at in that cycle. DReq drops on the edge that consumes DAck (or on the
// timeout edge, or on reset). DAck outside ACCESS is ignored.
// ---------------------------------------------------------------------------
module mem_stage #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        InValid,
  input  logic [31:0] Ins,
  input  logic [31:0] Result,
  input  logic [31:0] Rdata2,
  output logic        Stall,
  output logic        DReq,
  output logic        DWe,
  output logic [3:0]  DBe,
  output logic [31:0] DAddr,
  output logic [31:0] DWdata,
  input  logic [31:0] DRdata,
  input  logic        DAck,
  output logic        OutValid,
  output logic [31:0] WbData,
  output logic [31:0] WbIns,
  output logic        BusErr,
  output logic        AddrErr,
  output logic        DbgState
);

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SW  = 6'h2B;

  // Access size encoding used internally.
  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  // Last counter value before the abort; the abort happens in the
  // TIMEOUT_CYCLES-th ACCESS cycle, when the counter still holds N-1.
  localparam logic [9:0] TO_LAST = 10'(TIMEOUT_CYCLES - 1);

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_ACCESS = 1'b1
  } state_t;

  state_t state;

  // ---------------------------------------------------------------------------
  // Decode of the incoming instruction
  // ---------------------------------------------------------------------------
  logic        in_mem;
  logic        in_store;
  logic        in_uns;
  logic [1:0]  in_size;
  logic [1:0]  in_low;      // byte offset after forcing alignment to size
  logic        in_misalign;
  logic [3:0]  in_be;
  logic [31:0] in_wdata;

  always_comb begin
    in_mem   = 1'b1;
    in_store = 1'b0;
    in_uns   = 1'b0;
    in_size  = SZ_W;
    case (Ins[31:26])
      OP_LB:  in_size = SZ_B;
      OP_LH:  in_size = SZ_H;
      OP_LW:  in_size = SZ_W;
      OP_LBU: begin in_size = SZ_B; in_uns = 1'b1; end
      OP_LHU: begin in_size = SZ_H; in_uns = 1'b1; end
      OP_SB:  begin in_size = SZ_B; in_store = 1'b1; end
      OP_SH:  begin in_size = SZ_H; in_store = 1'b1; end
      OP_SW:  begin in_size = SZ_W; in_store = 1'b1; end
      default: in_mem = 1'b0;
    endcase
  end

  always_comb begin
    in_low   = 2'b00;
    in_be    = 4'b1111;
    in_wdata = Rdata2;
    case (in_size)
      SZ_B: begin
        in_low   = Result[1:0];
        in_be    = 4'b0001 << Result[1:0];
        in_wdata = {4{Rdata2[7:0]}};
      end
      SZ_H: begin
        in_low   = {Result[1], 1'b0};
        in_be    = Result[1] ? 4'b1100 : 4'b0011;
        in_wdata = {2{Rdata2[15:0]}};
      end
      default: begin
        in_low   = 2'b00;
        in_be    = 4'b1111;
        in_wdata = Rdata2;
      end
    endcase
  end

`ifdef MEM_ALIGN_CHECK_EN
  assign in_misalign = in_mem &
                       (((in_size == SZ_H) & Result[0]) |
                        ((in_size == SZ_W) & (|Result[1:0])));
`else
  assign in_misalign = 1'b0;
`endif

  // A well-formed memory op in IDLE starts a bus access.
  logic start_access;
  assign start_access = InValid & in_mem & ~in_misalign;

  // ---------------------------------------------------------------------------
  // State latched for the access in flight
  // ---------------------------------------------------------------------------
  logic [1:0]  size_q;
  logic        uns_q;
  logic        store_q;
  logic [1:0]  low_q;
  logic [31:0] ins_q;
  logic [9:0]  tcnt;

  logic timeout_hit;
  assign timeout_hit = (tcnt == TO_LAST);

  // Load lane selection and extension from the returned word.
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] load_data;

  always_comb begin
    case (low_q)
      2'd0:    rd_byte = DRdata[7:0];
      2'd1:    rd_byte = DRdata[15:8];
      2'd2:    rd_byte = DRdata[23:16];
      default: rd_byte = DRdata[31:24];
    endcase
    rd_half = low_q[1] ? DRdata[31:16] : DRdata[15:0];
    case (size_q)
      SZ_B:    load_data = uns_q ? {24'h0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
      SZ_H:    load_data = uns_q ? {16'h0, rd_half} : {{16{rd_half[15]}}, rd_half};
      default: load_data = DRdata;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Stall: in IDLE only while a new access is being accepted; in ACCESS until
  // the cycle that ends the access (DAck or timeout).
  // ---------------------------------------------------------------------------
  always_comb begin
    Stall = 1'b0;
    case (state)
      S_IDLE:   Stall = start_access;
      S_ACCESS: Stall = ~(DAck | timeout_hit);
      default:  Stall = 1'b0;
    endcase
  end

  assign DbgState = state;

  // ---------------------------------------------------------------------------
  // FSM and all registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= S_IDLE;
      tcnt     <= '0;
      size_q   <= SZ_B;
      uns_q    <= 1'b0;
      store_q  <= 1'b0;
      low_q    <= 2'b00;
      ins_q    <= '0;
      DReq     <= 1'b0;
      DWe      <= 1'b0;
      DBe      <= '0;
      DAddr    <= '0;
      DWdata   <= '0;
      OutValid <= 1'b0;
      WbData   <= '0;
      WbIns    <= '0;
      BusErr   <= 1'b0;
      AddrErr  <= 1'b0;
    end else begin
      // Status flags are single-cycle pulses.
      OutValid <= 1'b0;
      BusErr   <= 1'b0;
      AddrErr  <= 1'b0;

      case (state)
        S_IDLE: begin
          if (InValid) begin
            if (in_misalign) begin
              OutValid <= 1'b1;
              AddrErr  <= 1'b1;
              WbData   <= '0;
              WbIns    <= Ins;
            end else if (in_mem) begin
              size_q  <= in_size;
              uns_q   <= in_uns;
              store_q <= in_store;
              low_q   <= in_low;
              ins_q   <= Ins;
              tcnt    <= '0;
              DReq    <= 1'b1;
              DWe     <= in_store;
              DBe     <= in_be;
              DAddr   <= {Result[31:2], 2'b00};
              DWdata  <= in_wdata;
              state   <= S_ACCESS;
            end else begin
              OutValid <= 1'b1;
              WbData   <= Result;
              WbIns    <= Ins;
            end
          end
        end

        S_ACCESS: begin
          // DAck in the timeout cycle still counts as a normal completion.
          if (DAck) begin
            OutValid <= 1'b1;
            WbData   <= store_q ? 32'h0 : load_data;
            WbIns    <= ins_q;
            DReq     <= 1'b0;
            DWe      <= 1'b0;
            DBe      <= '0;
            tcnt     <= '0;
            state    <= S_IDLE;
          end else if (timeout_hit) begin
            OutValid <= 1'b1;
            BusErr   <= 1'b1;
            WbData   <= '0;
            WbIns    <= ins_q;
            DReq     <= 1'b0;
            DWe      <= 1'b0;
            DBe      <= '0;
            tcnt     <= '0;
            state    <= S_IDLE;
          end else begin
            tcnt <= tcnt + 10'd1;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// ---------------------------------------------------------------------------
// tb_mem_stage -- self-checking bench for mem_stage.
// Directed table of spec examples, hand-written reset/idle sequences, then
// random instructions whose expected results come from a behavioural model.
// ---------------------------------------------------------------------------
module tb_mem_stage;

  localparam int TO = 4;

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic        CLK = 1'b0;
  logic        RST;
  logic        InValid;
  logic [31:0] Ins;
  logic [31:0] Result;
  logic [31:0] Rdata2;
  logic        Stall;
  logic        DReq;
  logic        DWe;
  logic [3:0]  DBe;
  logic [31:0] DAddr;
  logic [31:0] DWdata;
  logic [31:0] DRdata;
  logic        DAck;
  logic        OutValid;
  logic [31:0] WbData;
  logic [31:0] WbIns;
  logic        BusErr;
  logic        AddrErr;
  logic        DbgState;

  always #5 CLK = ~CLK;

  mem_stage #(.TIMEOUT_CYCLES(TO)) dut (
    .CLK(CLK), .RST(RST), .InValid(InValid), .Ins(Ins), .Result(Result),
    .Rdata2(Rdata2), .Stall(Stall), .DReq(DReq), .DWe(DWe), .DBe(DBe),
    .DAddr(DAddr), .DWdata(DWdata), .DRdata(DRdata), .DAck(DAck),
    .OutValid(OutValid), .WbData(WbData), .WbIns(WbIns), .BusErr(BusErr),
    .AddrErr(AddrErr), .DbgState(DbgState)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h required 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [31:0] ins;
    logic [31:0] result;
    logic [31:0] rdata2;
    logic [31:0] rdata;
    int          ack;       // ACCESS cycle carrying DAck; 0 = never
    logic [31:0] exp_data;
    logic [3:0]  exp_be;
    logic [31:0] exp_addr;
    logic [31:0] exp_wdata;
    logic        exp_mem;   // a bus access is expected
    logic        exp_we;
    logic        exp_buserr;
    logic        exp_addrerr;
  } vec_t;

  function automatic vec_t mk(input logic [31:0] ins, result, rdata2, rdata,
                              input int ack, input logic [31:0] data,
                              input logic [3:0] be, input logic [31:0] addr, wdata,
                              input logic mem, we, buserr, addrerr);
    vec_t v;
    v.ins = ins; v.result = result; v.rdata2 = rdata2; v.rdata = rdata;
    v.ack = ack; v.exp_data = data; v.exp_be = be; v.exp_addr = addr;
    v.exp_wdata = wdata; v.exp_mem = mem; v.exp_we = we;
    v.exp_buserr = buserr; v.exp_addrerr = addrerr;
    return v;
  endfunction

  // ---------------------------------------------------------------------------
  // Behavioural reference model: opcode table plus plain arithmetic on the
  // address and data words.
  // ---------------------------------------------------------------------------
  function automatic vec_t model(input logic [31:0] ins, result, rdata2, rdata, input int ack);
    vec_t v;
    int size;
    bit is_load, sgn, known;
    int off;
    longint unsigned raw, span;
    v = mk(ins, result, rdata2, rdata, ack, result, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    known = 1; size = 4; is_load = 0; sgn = 0;
    case (ins[31:26])
      6'h20: begin size = 1; is_load = 1; sgn = 1; end
      6'h21: begin size = 2; is_load = 1; sgn = 1; end
      6'h23: begin size = 4; is_load = 1; end
      6'h24: begin size = 1; is_load = 1; end
      6'h25: begin size = 2; is_load = 1; end
      6'h28: size = 1;
      6'h29: size = 2;
      6'h2B: size = 4;
      default: known = 0;
    endcase
    if (!known) return v;
`ifdef MEM_ALIGN_CHECK_EN
    if ((result % size) != 0) begin
      v.exp_addrerr = 1'b1;
      v.exp_data = 32'h0;
      return v;
    end
`endif
    v.exp_mem  = 1'b1;
    v.exp_we   = !is_load;
    off        = int'(result % 4);
    off        = off - (off % size);
    v.exp_addr = result - (result % 4);
    v.exp_be   = 4'(((1 << size) - 1) << off);
    if (size == 1)      v.exp_wdata = rdata2[7:0] * 32'h0101_0101;
    else if (size == 2) v.exp_wdata = rdata2[15:0] * 32'h0001_0001;
    else                v.exp_wdata = rdata2;
    if (!(ack >= 1 && ack <= TO)) begin
      v.exp_buserr = 1'b1;
      v.exp_data = 32'h0;
    end else if (is_load) begin
      span = 64'd1 << (8 * size);
      raw  = (64'(rdata) >> (8 * off)) % span;
      if (sgn && raw >= span / 2) raw = raw + 64'h1_0000_0000 - span;
      v.exp_data = raw[31:0];
    end else begin
      v.exp_data = 32'h0;
    end
    return v;
  endfunction

  // ---------------------------------------------------------------------------
  // Driver: presents one instruction (called at posedge+1), walks the access,
  // and returns at posedge+1 of the cycle after the OutValid pulse was seen.
  // ---------------------------------------------------------------------------
  task automatic run_op(input vec_t v);
    int last;
    logic [31:0] e;
    InValid = 1'b1; Ins = v.ins; Result = v.result; Rdata2 = v.rdata2; DAck = 1'b0;
    exp_q.push_back(v.exp_data);
    @(negedge CLK);
    chk("issue_stall", 32'(Stall), 32'(v.exp_mem));
    chk("issue_dreq", 32'(DReq), 32'h0);
    chk("pulse_clear", 32'(OutValid), 32'h0);
    @(posedge CLK); #1;
    if (v.exp_mem) begin
      last = (v.ack > 0 && v.ack <= TO) ? v.ack : TO;
      for (int k = 1; k <= last; k++) begin
        DAck   = (k == v.ack);
        DRdata = (k == v.ack) ? v.rdata : $urandom;
        @(negedge CLK);
        chk("acc_dreq", 32'(DReq), 32'h1);
        chk("acc_dwe", 32'(DWe), 32'(v.exp_we));
        chk("acc_dbe", 32'(DBe), 32'(v.exp_be));
        chk("acc_daddr", DAddr, v.exp_addr);
        if (v.exp_we) chk("acc_dwdata", DWdata, v.exp_wdata);
        chk("acc_stall", 32'(Stall), 32'(k != last));
        @(posedge CLK); #1;
        DAck = 1'b0;
      end
    end
    InValid = 1'b0;
    @(negedge CLK);
    chk("out_valid", 32'(OutValid), 32'h1);
    e = exp_q.pop_front();
    chk("wb_data", WbData, e);
    chk("wb_ins", WbIns, v.ins);
    chk("bus_err", 32'(BusErr), 32'(v.exp_buserr));
    chk("addr_err", 32'(AddrErr), 32'(v.exp_addrerr));
    chk("done_dreq", 32'(DReq), 32'h0);
    chk("done_state", 32'(DbgState), 32'h0);
    @(posedge CLK); #1;
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  vec_t tbl[$];
  logic [5:0] pool[14] = '{6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2B,
                           6'h00, 6'h09, 6'h0F, 6'h22, 6'h26, 6'h2A};

  initial begin
    RST = 1'b1; InValid = 1'b0; Ins = '0; Result = '0; Rdata2 = '0;
    DRdata = '0; DAck = 1'b0;

    // Reset state
    repeat (2) @(posedge CLK);
    #1;
    @(negedge CLK);
    chk("rst_outvalid", 32'(OutValid), 32'h0);
    chk("rst_dreq", 32'(DReq), 32'h0);
    chk("rst_stall", 32'(Stall), 32'h0);
    chk("rst_wbdata", WbData, 32'h0);
    chk("rst_wbins", WbIns, 32'h0);
    chk("rst_dbe", 32'(DBe), 32'h0);
    chk("rst_state", 32'(DbgState), 32'h0);
    @(posedge CLK); #1;
    RST = 1'b0;

    // Idle with no instruction, then a stray DAck while idle
    @(negedge CLK);
    chk("idle_outvalid", 32'(OutValid), 32'h0);
    @(posedge CLK); #1;
    DAck = 1'b1; DRdata = 32'hFFFF_FFFF;
    @(posedge CLK); #1;
    DAck = 1'b0;
    @(negedge CLK);
    chk("stray_ack_outvalid", 32'(OutValid), 32'h0);
    chk("stray_ack_dreq", 32'(DReq), 32'h0);
    @(posedge CLK); #1;

    // Directed table (TO = 4)
    tbl.push_back(mk(32'h0085_1021, 32'h1234, 0, 0, 0, 32'h1234, 4'h0, 0, 0, 0, 0, 0, 0));          // ADDU
    tbl.push_back(mk(32'hA085_0002, 32'h102, 32'hAABB_CCDD, 0, 3, 0, 4'b0100, 32'h100, 32'hDDDD_DDDD, 1, 1, 0, 0)); // SB
    tbl.push_back(mk(32'h80A2_0003, 32'h103, 0, 32'h80FF_7F01, 2, 32'hFFFF_FF80, 4'b1000, 32'h100, 0, 1, 0, 0, 0)); // LB
    tbl.push_back(mk(32'h90A2_0003, 32'h103, 0, 32'h80FF_7F01, 1, 32'h0000_0080, 4'b1000, 32'h100, 0, 1, 0, 0, 0)); // LBU
    tbl.push_back(mk(32'h84A2_0002, 32'h102, 0, 32'h80FF_7F01, 2, 32'hFFFF_80FF, 4'b1100, 32'h100, 0, 1, 0, 0, 0)); // LH
    tbl.push_back(mk(32'h94A2_0002, 32'h102, 0, 32'h80FF_7F01, 1, 32'h0000_80FF, 4'b1100, 32'h100, 0, 1, 0, 0, 0)); // LHU hi
    tbl.push_back(mk(32'h94A2_0000, 32'h100, 0, 32'h80FF_7F01, 1, 32'h0000_7F01, 4'b0011, 32'h100, 0, 1, 0, 0, 0)); // LHU lo
    tbl.push_back(mk(32'h80A2_0001, 32'h101, 0, 32'h80FF_7F01, 1, 32'h0000_007F, 4'b0010, 32'h100, 0, 1, 0, 0, 0)); // LB lane1
    tbl.push_back(mk(32'h8CA2_0000, 32'h200, 0, 32'hDEAD_BEEF, 1, 32'hDEAD_BEEF, 4'b1111, 32'h200, 0, 1, 0, 0, 0)); // LW
    tbl.push_back(mk(32'hA4A2_0000, 32'h206, 32'h1234_5678, 0, 2, 0, 4'b1100, 32'h204, 32'h5678_5678, 1, 1, 0, 0)); // SH
    tbl.push_back(mk(32'hACA2_0000, 32'h300, 32'hCAFE_F00D, 0, 1, 0, 4'b1111, 32'h300, 32'hCAFE_F00D, 1, 1, 0, 0)); // SW
    tbl.push_back(mk(32'h8CA2_0000, 32'h400, 0, 32'h5555_5555, 0, 0, 4'b1111, 32'h400, 0, 1, 0, 1, 0));           // LW timeout
    tbl.push_back(mk(32'h8CA2_0004, 32'h404, 0, 32'h0BAD_F00D, TO, 32'h0BAD_F00D, 4'b1111, 32'h404, 0, 1, 0, 0, 0)); // ack at timeout
    tbl.push_back(mk(32'hA0A2_0003, 32'h003, 32'h0000_00EE, 0, TO + 1, 0, 4'b1000, 32'h0, 32'hEEEE_EEEE, 1, 1, 1, 0)); // SB late ack
`ifdef MEM_ALIGN_CHECK_EN
    tbl.push_back(mk(32'h8CA2_0101, 32'h101, 0, 32'h1122_3344, 1, 0, 4'h0, 0, 0, 0, 0, 0, 1));              // LW misaligned
    tbl.push_back(mk(32'hA4A2_0203, 32'h203, 32'h0000_BEEF, 0, 1, 0, 4'h0, 0, 0, 0, 0, 0, 1));              // SH misaligned
`else
    tbl.push_back(mk(32'h8CA2_0101, 32'h101, 0, 32'h1122_3344, 1, 32'h1122_3344, 4'b1111, 32'h100, 0, 1, 0, 0, 0));
    tbl.push_back(mk(32'hA4A2_0203, 32'h203, 32'h0000_BEEF, 0, 1, 0, 4'b1100, 32'h200, 32'hBEEF_BEEF, 1, 1, 0, 0));
`endif
    tbl.push_back(mk(32'h3C01_1234, 32'h1234_0000, 0, 0, 0, 32'h1234_0000, 4'h0, 0, 0, 0, 0, 0, 0));        // LUI
    tbl.push_back(mk(32'h88A2_0000, 32'h77, 0, 0, 0, 32'h77, 4'h0, 0, 0, 0, 0, 0, 0));                        // LWL: non-mem

    foreach (tbl[i]) run_op(tbl[i]);

    // Reset in the second ACCESS cycle aborts the load
    InValid = 1'b1; Ins = 32'h8CA2_0500; Result = 32'h500; Rdata2 = '0;
    @(posedge CLK); #1;             // ACCESS cycle 1
    @(posedge CLK); #1;             // ACCESS cycle 2
    RST = 1'b1;
    @(negedge CLK);
    chk("pre_rst_dreq", 32'(DReq), 32'h1);
    @(posedge CLK); #1;
    RST = 1'b0; InValid = 1'b0;
    @(negedge CLK);
    chk("abort_dreq", 32'(DReq), 32'h0);
    chk("abort_outvalid", 32'(OutValid), 32'h0);
    chk("abort_wbdata", WbData, 32'h0);
    chk("abort_wbins", WbIns, 32'h0);
    chk("abort_daddr", DAddr, 32'h0);
    chk("abort_stall", 32'(Stall), 32'h0);
    DAck = 1'b1; DRdata = 32'h1357_9BDF;
    @(posedge CLK); #1;
    DAck = 1'b0;
    @(negedge CLK);
    chk("late_ack_outvalid", 32'(OutValid), 32'h0);
    chk("late_ack_dreq", 32'(DReq), 32'h0);
    @(posedge CLK); #1;

    // Random instructions against the model, issued back to back
    for (int n = 0; n < 150; n++) begin
      logic [31:0] ins;
      ins = {pool[$urandom_range(0, 13)], 26'($urandom)};
      run_op(model(ins, $urandom, $urandom, $urandom, $urandom_range(0, TO + 2)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
